// File: rtl/smm_pkg.sv
// Shared types and constants for the sparse matrix multiplier CSR packer.
package smm_pkg;

  localparam int unsigned N_DIM = 32;
  localparam int unsigned ROW_W = 5;
  localparam int unsigned COL_W = 5;
  localparam int unsigned VAL_W = 9;
  localparam int unsigned PTR_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_SCAN,
    ST_EMIT_PTR,
    ST_EMIT_ENT
  } state_e;

  typedef struct packed {
    logic [COL_W-1:0] col;
    logic [VAL_W-1:0] val;
  } entry_t;

endpackage

// File: rtl/smm_csr_entry_buf.sv
// Nonzero entry store: single write port with auto-incrementing pointer,
// indexed combinational read.
module smm_csr_entry_buf
  import smm_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             wr_en_i,
  input  entry_t           wr_data_i,
  input  logic [PTR_W-1:0] rd_idx_i,
  output entry_t           rd_data_c,
  output logic [PTR_W-1:0] wp_o,
  output logic             full_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wp_q;
  logic [PTR_W-1:0] wp_d;
  logic             wr_ok;

  assign full_c    = (wp_q == PTR_W'(DEPTH));
  assign wr_ok     = wr_en_i && !full_c;
  assign wp_o      = wp_q;
  assign rd_data_c = mem_q[AW'(rd_idx_i)];

  always_comb begin
    wp_d = wp_q;
    if (clr_i) begin
      wp_d = '0;
    end else if (wr_ok) begin
      wp_d = wp_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
    end else begin
      wp_q <= wp_d;
    end
  end

  // Storage needs no reset: only entries below wp are ever read.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[AW'(wp_q)] <= wr_data_i;
    end
  end

endmodule

// File: rtl/smm_csr_packer.sv
// Packs a row-major COO result burst into a CSR image streamed over valid/ready.
// Optional input-order checking is enabled by defining SMM_CSR_ORDER_CHECK_EN.
module smm_csr_packer
  import smm_pkg::*;
#(
  parameter int unsigned MAX_NNZ = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [ROW_W-1:0] in_row,
  input  logic [COL_W-1:0] in_col,
  input  logic [VAL_W-1:0] in_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sel,
  output logic [PTR_W-1:0] out_idx,
  output logic [VAL_W-1:0] out_val,
  output logic             out_last,
  output logic             overflow,
  output logic             order_err
);

  localparam int unsigned PIDX_W = 6;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] cnt_q [N_DIM];
  logic [PTR_W-1:0] cnt_d [N_DIM];
  logic [PTR_W-1:0] acc_q, acc_d;
  logic [ROW_W-1:0] scan_idx_q, scan_idx_d;
  logic [PIDX_W-1:0] pidx_q, pidx_d;
  logic [PTR_W-1:0] eidx_q, eidx_d;
  logic             out_valid_q, out_valid_d;
  logic             out_sel_q, out_sel_d;
  logic [PTR_W-1:0] out_idx_q, out_idx_d;
  logic [VAL_W-1:0] out_val_q, out_val_d;
  logic             out_last_q, out_last_d;
  logic             overflow_q, overflow_d;

  logic             take, nz, store, xfer, done, have_word, load;
  logic             buf_full;
  logic [PTR_W-1:0] buf_wp;
  entry_t           buf_rd;

  assign take  = in_valid && (state_q == ST_IDLE || state_q == ST_COLLECT);
  assign nz    = (in_val != '0);
  assign store = take && nz && !buf_full;
  assign xfer  = out_valid_q && out_ready;
  assign done  = xfer && out_last_q;

  // A new word may enter the output register when it is empty or draining.
  assign have_word = (state_q == ST_EMIT_PTR && pidx_q <= PIDX_W'(N_DIM)) ||
                     (state_q == ST_EMIT_ENT && eidx_q < buf_wp);
  assign load      = have_word && (!out_valid_q || out_ready);

  smm_csr_entry_buf #(.DEPTH(MAX_NNZ)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (done),
    .wr_en_i   (take && nz),
    .wr_data_i ('{col: in_col, val: in_val}),
    .rd_idx_i  (eidx_q),
    .rd_data_c (buf_rd),
    .wp_o      (buf_wp),
    .full_c    (buf_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (in_valid) state_d = ST_COLLECT;
      ST_COLLECT:  if (!in_valid) state_d = ST_SCAN;
      ST_SCAN:     if (scan_idx_q == ROW_W'(N_DIM - 1)) state_d = ST_EMIT_PTR;
      ST_EMIT_PTR: begin
        if (load && pidx_q == PIDX_W'(N_DIM) && buf_wp != '0) begin
          state_d = ST_EMIT_ENT;
        end else if (done) begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT_ENT: if (done) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Counters, in-place prefix sum (cnt becomes ptr) and output word register.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    scan_idx_d  = scan_idx_q;
    pidx_d      = pidx_q;
    eidx_d      = eidx_q;
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    out_idx_d   = out_idx_q;
    out_val_d   = out_val_q;
    out_last_d  = out_last_q;
    overflow_d  = overflow_q;

    if (done) begin
      cnt_d      = '{default: '0};
      acc_d      = '0;
      scan_idx_d = '0;
      pidx_d     = '0;
      eidx_d     = '0;
    end

    if (state_q == ST_IDLE && in_valid) overflow_d = 1'b0;
    if (take && nz && buf_full) overflow_d = 1'b1;
    if (store) cnt_d[in_row] = cnt_q[in_row] + PTR_W'(1);

    if (state_q == ST_SCAN) begin
      cnt_d[scan_idx_q] = acc_q;
      acc_d             = acc_q + cnt_q[scan_idx_q];
      scan_idx_d        = scan_idx_q + ROW_W'(1);
    end

    if (xfer) begin
      out_valid_d = 1'b0;
      if (out_last_q) out_last_d = 1'b0;
    end

    if (load) begin
      out_valid_d = 1'b1;
      if (state_q == ST_EMIT_PTR) begin
        out_sel_d  = 1'b0;
        out_val_d  = '0;
        out_idx_d  = (pidx_q == PIDX_W'(N_DIM)) ? acc_q : cnt_q[pidx_q[ROW_W-1:0]];
        out_last_d = (pidx_q == PIDX_W'(N_DIM)) && (buf_wp == '0);
        pidx_d     = pidx_q + PIDX_W'(1);
      end else begin
        out_sel_d  = 1'b1;
        out_idx_d  = PTR_W'(buf_rd.col);
        out_val_d  = buf_rd.val;
        out_last_d = (eidx_q == buf_wp - PTR_W'(1));
        eidx_d     = eidx_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '{default: '0};
      acc_q       <= '0;
      scan_idx_q  <= '0;
      pidx_q      <= '0;
      eidx_q      <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= 1'b0;
      out_idx_q   <= '0;
      out_val_q   <= '0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      scan_idx_q  <= scan_idx_d;
      pidx_q      <= pidx_d;
      eidx_q      <= eidx_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      out_idx_q   <= out_idx_d;
      out_val_q   <= out_val_d;
      out_last_q  <= out_last_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;
  assign out_idx   = out_idx_q;
  assign out_val   = out_val_q;
  assign out_last  = out_last_q;
  assign overflow  = overflow_q;

`ifdef SMM_CSR_ORDER_CHECK_EN
  logic             order_err_q, order_err_d;
  logic             prev_vld_q, prev_vld_d;
  logic [ROW_W-1:0] prev_row_q, prev_row_d;
  logic [COL_W-1:0] prev_col_q, prev_col_d;

  // Compare each stored nonzero against the previously stored coordinate.
  always_comb begin
    order_err_d = order_err_q;
    prev_vld_d  = prev_vld_q;
    prev_row_d  = prev_row_q;
    prev_col_d  = prev_col_q;
    if (state_q == ST_IDLE && in_valid) begin
      order_err_d = 1'b0;
      prev_vld_d  = 1'b0;
    end
    if (store) begin
      if (state_q == ST_COLLECT && prev_vld_q &&
          (in_row < prev_row_q || (in_row == prev_row_q && in_col <= prev_col_q))) begin
        order_err_d = 1'b1;
      end
      prev_vld_d = 1'b1;
      prev_row_d = in_row;
      prev_col_d = in_col;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      order_err_q <= 1'b0;
      prev_vld_q  <= 1'b0;
      prev_row_q  <= '0;
      prev_col_q  <= '0;
    end else begin
      order_err_q <= order_err_d;
      prev_vld_q  <= prev_vld_d;
      prev_row_q  <= prev_row_d;
      prev_col_q  <= prev_col_d;
    end
  end

  assign order_err = order_err_q;
`else
  assign order_err = 1'b0;
`endif

endmodule
